// File: rtl/moxie_prefetch_wb.sv
// Wishbone instruction prefetcher for the Moxie fetch stage: issues single-beat
// classic reads ahead of decode and buffers returned words in a small FIFO.
module moxie_prefetch_wb #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h00001000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [ADDR_W-1:0]        wb_adr_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [DATA_W/8-1:0]      wb_sel_o,
    input  logic [DATA_W-1:0]        wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        flush_pc_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [ADDR_W-1:0]        pc_o,
    output logic                     err_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned       PTR_W      = $clog2(DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam int unsigned       ENT_W      = DATA_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              stb_q, stb_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic              push, push_err, pop, valid, term, room;
    logic [ADDR_W-1:0] flush_pc;
    logic [CNT_W-1:0]  after_push;
    logic [ENT_W-1:0]  head;

    assign valid      = (count_q != '0);
    assign pop        = valid && ready_i && !flush_i;
    assign term       = stb_q && (wb_ack_i || wb_err_i);
    assign flush_pc   = flush_pc_i & ALIGN_MASK;
    // Room is judged after this cycle's push and any simultaneous pop.
    assign after_push = count_q + CNT_W'(1) - CNT_W'(pop);
    assign room       = (after_push < DEPTH_C);

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        adr_d    = adr_q;
        pc_d     = pc_q;
        push     = 1'b0;
        push_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    pc_d    = flush_pc;
                    adr_d   = flush_pc;
                    stb_d   = 1'b1;
                    state_d = REQ;
                end else if (count_q < DEPTH_C) begin
                    adr_d   = pc_q;
                    stb_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush_i) begin
                    pc_d = flush_pc;
                    if (term) begin
                        adr_d = flush_pc;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (wb_err_i) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    stb_d    = 1'b0;
                    state_d  = HALT;
                end else if (wb_ack_i) begin
                    push  = 1'b1;
                    pc_d  = adr_q + STEP;
                    adr_d = adr_q + STEP;
                    if (!room) begin
                        stb_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                // The abandoned cycle must still terminate; its data is dropped.
                if (flush_i) begin
                    pc_d = flush_pc;
                end
                if (term) begin
                    adr_d   = flush_i ? flush_pc : pc_q;
                    state_d = REQ;
                end
            end
            HALT: begin
                if (flush_i) begin
                    pc_d    = flush_pc;
                    adr_d   = flush_pc;
                    stb_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            stb_q    <= 1'b0;
            adr_q    <= RESET_PC;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            adr_q    <= adr_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && push) begin
            mem_q[wr_ptr_q] <= {push_err, adr_q, wb_dat_i};
        end
    end

    // Storage is not reset; outputs are masked to zero whenever the FIFO is empty.
    assign head     = mem_q[rd_ptr_q];
    assign valid_o  = valid;
    assign data_o   = valid ? head[DATA_W-1:0] : '0;
    assign pc_o     = valid ? head[DATA_W +: ADDR_W] : '0;
    assign err_o    = valid && head[ENT_W-1];
    assign count_o  = count_q;

    assign wb_adr_o = adr_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = '1;

endmodule

// File: tb/tb_moxie_prefetch_wb.sv
// Directed bench for moxie_prefetch_wb with a scripted Wishbone slave whose
// read data is derived from the request address.
module tb_moxie_prefetch_wb;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [31:0] data_o, pc_o;
    logic        err_o, valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  count_o;

    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic        man_err = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          acks = 0;

    assign wb_ack_i = auto_ack ? wb_stb_o : man_ack;
    assign wb_err_i = man_err;
    assign wb_dat_i = wb_adr_o ^ K;

    always #5 clk = ~clk;

    moxie_prefetch_wb #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h00001000)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .data_o(data_o), .pc_o(pc_o), .err_o(err_o), .valid_o(valid_o),
        .ready_i(ready_i), .count_o(count_o)
    );

    always @(posedge clk) begin
        if (rst_i && wb_stb_o && wb_ack_i && !wb_err_i) acks++;
    end

    always @(negedge clk) begin
        if (rst_i) begin
            checks++;
            assert (wb_cyc_o === wb_stb_o) else begin
                errors++;
                $error("FAIL cyc_eq_stb: got %b want %b", wb_cyc_o, wb_stb_o);
            end
            checks++;
            assert (!(wb_stb_o && count_o == 3'd4)) else begin
                errors++;
                $error("FAIL req_while_full: got stb=%b count=%0d want no request when full", wb_stb_o, count_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        chk({tag, "_adr"}, wb_adr_o, 32'h1000);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_count"}, {29'd0, count_o}, 32'd0);
        chk({tag, "_data"}, data_o, 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
    endtask

    initial begin
        // Reset values and static bus signals
        tick();
        tick();
        chk_reset_state("rst");
        chk("we", {31'd0, wb_we_o}, 32'd0);
        chk("sel", {28'd0, wb_sel_o}, 32'hF);

        // Zero-wait slave, decoder always ready
        auto_ack = 1'b1;
        ready_i  = 1'b1;
        rst_i    = 1'b1;
        tick();
        chk("t1_stb_first", {31'd0, wb_stb_o}, 32'd1);
        chk("t1_adr_first", wb_adr_o, 32'h1000);
        chk("t1_valid_first", {31'd0, valid_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_pc", pc_o, 32'h1000 + 32'(4 * i));
            chk("t1_data", data_o, (32'h1000 + 32'(4 * i)) ^ K);
            chk("t1_count", {29'd0, count_o}, 32'd1);
            chk("t1_stb", {31'd0, wb_stb_o}, 32'd1);
        end

        // Decoder stalled: FIFO fills to DEPTH, then one pop admits one request
        rst_i   = 1'b0;
        ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
        acks  = 0;
        tick();
        repeat (4) tick();
        chk("t2_count_full", {29'd0, count_o}, 32'd4);
        chk("t2_stb_idle", {31'd0, wb_stb_o}, 32'd0);
        chk("t2_acks", 32'(acks), 32'd4);
        chk("t2_head_pc", pc_o, 32'h1000);
        tick();
        chk("t2_count_hold", {29'd0, count_o}, 32'd4);
        chk("t2_stb_hold", {31'd0, wb_stb_o}, 32'd0);
        chk("t2_head_hold", data_o, 32'h1000 ^ K);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t2_count_pop", {29'd0, count_o}, 32'd3);
        chk("t2_pc_pop", pc_o, 32'h1004);
        tick();
        chk("t2_stb_refill", {31'd0, wb_stb_o}, 32'd1);
        chk("t2_adr_refill", wb_adr_o, 32'h1010);
        tick();
        chk("t2_count_refull", {29'd0, count_o}, 32'd4);
        chk("t2_stb_refull", {31'd0, wb_stb_o}, 32'd0);
        chk("t2_acks_total", 32'(acks), 32'd5);

        // Flush while the request to 0x1008 is still waiting
        auto_ack = 1'b0;
        ready_i  = 1'b1;
        rst_i    = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        man_ack = 1'b1;
        tick();
        tick();
        man_ack    = 1'b0;
        chk("t3_adr_wait", wb_adr_o, 32'h1008);
        flush_i    = 1'b1;
        flush_pc_i = 32'h2002;
        tick();
        flush_i = 1'b0;
        chk("t3_count_flush", {29'd0, count_o}, 32'd0);
        chk("t3_valid_flush", {31'd0, valid_o}, 32'd0);
        chk("t3_stb_disc", {31'd0, wb_stb_o}, 32'd1);
        chk("t3_adr_disc", wb_adr_o, 32'h1008);
        tick();
        chk("t3_adr_disc2", wb_adr_o, 32'h1008);
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t3_dropped", {31'd0, valid_o}, 32'd0);
        chk("t3_stb_new", {31'd0, wb_stb_o}, 32'd1);
        chk("t3_adr_new", wb_adr_o, 32'h2000);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t3_pc_new", pc_o, 32'h2000);
        chk("t3_data_new", data_o, 32'h2000 ^ K);

        // Flush in the same cycle as an ack
        man_ack    = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h4000;
        tick();
        man_ack = 1'b0;
        flush_i = 1'b0;
        chk("t4_valid", {31'd0, valid_o}, 32'd0);
        chk("t4_count", {29'd0, count_o}, 32'd0);
        chk("t4_adr", wb_adr_o, 32'h4000);
        chk("t4_stb", {31'd0, wb_stb_o}, 32'd1);

        // Bus error on 0x1004 halts fetching until flush
        ready_i = 1'b0;
        rst_i   = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        man_err = 1'b1;
        tick();
        man_err = 1'b0;
        chk("t5_count", {29'd0, count_o}, 32'd2);
        chk("t5_stb_halt", {31'd0, wb_stb_o}, 32'd0);
        chk("t5_head_err", {31'd0, err_o}, 32'd0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("t5_err_pc", pc_o, 32'h1004);
        chk("t5_err_flag", {31'd0, err_o}, 32'd1);
        chk("t5_err_valid", {31'd0, valid_o}, 32'd1);
        tick();
        tick();
        chk("t5_still_halt", {31'd0, wb_stb_o}, 32'd0);
        flush_i    = 1'b1;
        flush_pc_i = 32'h3000;
        tick();
        flush_i = 1'b0;
        chk("t5_resume_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("t5_resume_adr", wb_adr_o, 32'h3000);
        chk("t5_resume_valid", {31'd0, valid_o}, 32'd0);

        // ack and err together: err wins
        man_ack = 1'b1;
        man_err = 1'b1;
        tick();
        man_ack = 1'b0;
        man_err = 1'b0;
        chk("t5b_err", {31'd0, err_o}, 32'd1);
        chk("t5b_pc", pc_o, 32'h3000);
        chk("t5b_stb", {31'd0, wb_stb_o}, 32'd0);

        // Address wrap, with a misaligned flush target
        flush_i    = 1'b1;
        flush_pc_i = 32'hFFFF_FFFE;
        tick();
        flush_i = 1'b0;
        chk("t6_adr_top", wb_adr_o, 32'hFFFF_FFFC);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t6_adr_wrap", wb_adr_o, 32'h0000_0000);
        chk("t6_stb_wrap", {31'd0, wb_stb_o}, 32'd1);
        chk("t6_pc_top", pc_o, 32'hFFFF_FFFC);

        // Reset during an outstanding request, with a late ack
        rst_i   = 1'b0;
        man_ack = 1'b1;
        tick();
        chk_reset_state("t7");
        tick();
        chk("t7_count_late_ack", {29'd0, count_o}, 32'd0);
        man_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
